// File: rtl/controle_medida_hcsr04_if.sv
// ===========================================================================
// controle_medida_hcsr04_if : sensor/datapath signal bundle for the HC-SR04 control unit
// Rev 1.0
// ===========================================================================
`default_nettype none

interface controle_medida_hcsr04_if;
  logic       medir;
  logic       echo;
  logic       fim_bcd;
  logic       trigger;
  logic       zera_tick;
  logic       zera_bcd;
  logic       conta_tick;
  logic       registra;
  logic       pronto;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    output medir, echo, fim_bcd,
    input  trigger, zera_tick, zera_bcd, conta_tick, registra, pronto, timeout, db_estado
  );

  modport slave (
    input  medir, echo, fim_bcd,
    output trigger, zera_tick, zera_bcd, conta_tick, registra, pronto, timeout, db_estado
  );
endinterface

`default_nettype wire

// File: rtl/controle_medida_hcsr04.sv
// ===========================================================================
// controle_medida_hcsr04 : Moore FSM sequencing trigger, echo timing and result strobes
// Rev 1.0
// ===========================================================================
`default_nettype none

module controle_medida_hcsr04 #(
  parameter int TRIG_CICLOS    = 500,
  parameter int TIMEOUT_CICLOS = 1_500_000,
  parameter int NT             = 21
) (
  input  wire logic                clock,
  input  wire logic                reset_n,
  controle_medida_hcsr04_if.slave  bus
);

  typedef enum logic [2:0] {
    INICIAL       = 3'd0,
    PREPARACAO    = 3'd1,
    ENVIA_TRIGGER = 3'd2,
    ESPERA_ECHO   = 3'd3,
    MEDIDA        = 3'd4,
    ARMAZENA      = 3'd5,
    FINAL         = 3'd6,
    ERRO          = 3'd7
  } estado_t;

  localparam logic [NT-1:0] TRIG_FIM    = NT'(TRIG_CICLOS - 1);
  localparam logic [NT-1:0] TIMEOUT_FIM = NT'(TIMEOUT_CICLOS - 1);

  estado_t       estado_q, estado_d;
  logic [NT-1:0] timer_q, timer_d;
  logic          echo_meta_q, echo_s_q, echo_d_q;
  logic          borda_sobe, borda_desce, trig_fim, tempo_esgotado;

  assign borda_sobe     = echo_s_q & ~echo_d_q;
  assign borda_desce    = ~echo_s_q & echo_d_q;
  assign trig_fim       = (timer_q == TRIG_FIM);
  // >= keeps medida bounded even if it was entered with the timer already at its limit
  assign tempo_esgotado = (timer_q >= TIMEOUT_FIM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= INICIAL;
      timer_q     <= '0;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_d_q    <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      timer_q     <= timer_d;
      echo_meta_q <= bus.echo;
      echo_s_q    <= echo_meta_q;
      echo_d_q    <= echo_s_q;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:       if (bus.medir) estado_d = PREPARACAO;
      PREPARACAO:    estado_d = ENVIA_TRIGGER;
      ENVIA_TRIGGER: if (trig_fim) estado_d = ESPERA_ECHO;
      ESPERA_ECHO: begin
        if (borda_sobe)          estado_d = MEDIDA;
        else if (tempo_esgotado) estado_d = ERRO;
      end
      MEDIDA: begin
        if (bus.fim_bcd || tempo_esgotado) estado_d = ERRO;
        else if (borda_desce)              estado_d = ARMAZENA;
      end
      ARMAZENA:      estado_d = FINAL;
      FINAL:         estado_d = INICIAL;
      ERRO:          estado_d = INICIAL;
      default:       estado_d = INICIAL;
    endcase
  end

  // The timer carries over from espera_echo into medida so the timeout covers wait plus echo.
  always_comb begin
    timer_d = timer_q + 1'b1;
    if ((estado_d != estado_q) && !((estado_q == ESPERA_ECHO) && (estado_d == MEDIDA)))
      timer_d = '0;
  end

  assign bus.zera_tick  = (estado_q == PREPARACAO);
  assign bus.zera_bcd   = (estado_q == PREPARACAO);
  assign bus.trigger    = (estado_q == ENVIA_TRIGGER);
  assign bus.conta_tick = (estado_q == MEDIDA);
  assign bus.registra   = (estado_q == ARMAZENA);
  assign bus.pronto     = (estado_q == FINAL);
  assign bus.timeout    = (estado_q == ERRO);
  assign bus.db_estado  = {1'b0, estado_q};

endmodule

`default_nettype wire
